// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: turns execute-stage branch/JALR resolution into a fetch-PC correction plus IF/ID, ID/EX squash.
// Latency: 0 cycles (combinational redirect in the resolve cycle); a redirect hit by stall_IF is held in PEND until fetch accepts it.
// Backpressure: stall masks resolve events (E re-presents them); stall_IF parks the correction in pend_pc. Optional counters under `BPU_PERF_EN.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        stall,
    input  logic [4:0]  E_op,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_target,
    input  logic        t_pnt,
    input  logic        nt_pt,
    input  logic        pred_jump,
    input  logic [31:0] pc_pred,
    output logic [1:0]  next_pc_sel,
    output logic [31:0] pc_redirect,
    output logic        redirect_valid,
    output logic        flush_D,
    output logic        flush_E,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_PRED = 2'b01;
    localparam logic [1:0] SEL_REDIR = 2'b10;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;

    logic        is_br;
    logic        is_jalr;
    logic        br_mispred;
    logic        res_evt;
    logic [31:0] corr_pc;

    // The PC mux lives outside this block; pc_pred is on the port list only
    // so the predictor/PC wiring stays in one place.
    logic        unused_pc_pred;
    assign unused_pc_pred = ^pc_pred;

    // Decode the E-stage instruction and qualify a resolve event. While a
    // redirect is pending, E holds wrong-path work, so events are masked.
    always_comb begin
        is_br      = (E_op == OP_BRANCH);
        is_jalr    = (E_op == OP_JALR);
        br_mispred = t_pnt | nt_pt;
        res_evt    = (state_q == ST_IDLE) && !stall &&
                     ((is_br && br_mispred) || is_jalr);
        // Taken-mispredict and JALR go to the resolved target; a
        // not-taken-mispredict falls through (wraps naturally at 2^32).
        if (is_jalr || t_pnt) begin
            corr_pc = E_target;
        end else begin
            corr_pc = E_pc + 32'd4;
        end
    end

    // Next-state: park the correction when fetch cannot take it, and leave
    // PEND on the first cycle fetch is free (the redirect lands that cycle).
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (res_evt && stall_IF) begin
                    state_d   = ST_PEND;
                    pend_pc_d = corr_pc;
                end
            end
            ST_PEND: begin
                if (!stall_IF) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and the latched pending address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Output select: a redirect (fresh or pending) beats the predictor and
    // squashes both younger pipeline registers. Reset forces quiet outputs
    // immediately, even mid-PEND.
    always_comb begin
        redirect_valid = 1'b0;
        pc_redirect    = RESET_PC;
        next_pc_sel    = SEL_PC4;
        if (rst) begin
            redirect_valid = (state_q == ST_PEND) || res_evt;
            if (state_q == ST_PEND) begin
                pc_redirect = pend_pc_q;
            end else if (res_evt) begin
                pc_redirect = corr_pc;
            end else begin
                pc_redirect = pend_pc_q;
            end
            if (redirect_valid) begin
                next_pc_sel = SEL_REDIR;
            end else if (pred_jump) begin
                next_pc_sel = SEL_PRED;
            end
        end
        flush_D = redirect_valid;
        flush_E = redirect_valid;
    end

`ifdef BPU_PERF_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;
    logic        cnt_en;

    // Only conditional branches are counted, and only when E advances and
    // no redirect is pending (E holds wrong-path work while in PEND).
    assign cnt_en = (state_q == ST_IDLE) && !stall && is_br;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else if (cnt_en) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (br_mispred) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized + directed bench for branch_redirect_ctrl with a behavioural reference model.
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
// Counter expectations follow `BPU_PERF_EN the same way as the design build.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_IF;
    logic        stall;
    logic [4:0]  E_op;
    logic [31:0] E_pc;
    logic [31:0] E_target;
    logic        t_pnt;
    logic        nt_pt;
    logic        pred_jump;
    logic [31:0] pc_pred;
    logic [1:0]  next_pc_sel;
    logic [31:0] pc_redirect;
    logic        redirect_valid;
    logic        flush_D;
    logic        flush_E;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_redirect_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_IF       (stall_IF),
        .stall          (stall),
        .E_op           (E_op),
        .E_pc           (E_pc),
        .E_target       (E_target),
        .t_pnt          (t_pnt),
        .nt_pt          (nt_pt),
        .pred_jump      (pred_jump),
        .pc_pred        (pc_pred),
        .next_pc_sel    (next_pc_sel),
        .pc_redirect    (pc_redirect),
        .redirect_valid (redirect_valid),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending correction is just "is one owed, and where to".
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          m_evt;
    logic [31:0] m_want;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and compare every output against the model.
    task automatic cyc(input logic r, input logic sif, input logic st, input logic [4:0] op,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic t, input logic nt,
                       input logic pj, input logic [31:0] pp);
        logic        e_vld;
        logic [31:0] e_pc;
        logic [1:0]  e_sel;
        logic [31:0] e_br;
        logic [31:0] e_mis;
        rst = r; stall_IF = sif; stall = st; E_op = op; E_pc = pc; E_target = tgt;
        t_pnt = t; nt_pt = nt; pred_jump = pj; pc_pred = pp;
        #3;
        if (!r) begin
            m_pend = 0; m_pend_pc = TB_RESET_PC; m_br = 0; m_mis = 0;
        end
        m_evt  = r && !m_pend && !st &&
                 ((op == 5'b11000 && (t || nt)) || op == 5'b11001);
        m_want = (op == 5'b11001 || t) ? tgt : pc + 32'd4;
        e_vld  = r && (m_pend || m_evt);
        if (!r)          e_pc = TB_RESET_PC;
        else if (m_pend) e_pc = m_pend_pc;
        else if (m_evt)  e_pc = m_want;
        else             e_pc = m_pend_pc;
        e_sel = e_vld ? 2'b10 : ((r && pj) ? 2'b01 : 2'b00);
`ifdef BPU_PERF_EN
        e_br = m_br; e_mis = m_mis;
`else
        e_br = 32'd0; e_mis = 32'd0;
`endif
        check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_vld});
        check_eq("flush_D", {31'd0, flush_D}, {31'd0, e_vld});
        check_eq("flush_E", {31'd0, flush_E}, {31'd0, e_vld});
        check_eq("next_pc_sel", {30'd0, next_pc_sel}, {30'd0, e_sel});
        check_eq("pc_redirect", pc_redirect, e_pc);
        check_eq("branch_cnt", branch_cnt, e_br);
        check_eq("mispred_cnt", mispred_cnt, e_mis);
    endtask

    // Clock edge: advance the model with the inputs that were held across it.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (!m_pend && !stall && E_op == 5'b11000) begin
                m_br = m_br + 32'd1;
                if (t_pnt || nt_pt) m_mis = m_mis + 32'd1;
            end
            if (m_pend) begin
                if (!stall_IF) m_pend = 0;
            end else if (m_evt && stall_IF) begin
                m_pend    = 1;
                m_pend_pc = m_want;
            end
        end
        #1;
    endtask

    task automatic idle(input logic sif);
        cyc(1, sif, 0, 5'b00100, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int flushes;
        logic [4:0] op;
        logic [31:0] rpc;

        // Reset in IDLE, with a predictor request that must be suppressed.
        cyc(0, 0, 0, 5'b11000, 32'h10, 32'h20, 1, 0, 1, 32'h300);
        check_eq("rst_pc", pc_redirect, TB_RESET_PC);
        check_eq("rst_sel", {30'd0, next_pc_sel}, 32'd0);
        tick();
        cyc(0, 0, 0, 5'b00000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        tick();

        // Taken-mispredict: redirect in the same cycle, gone the next.
        cyc(1, 0, 0, 5'b11000, 32'h100, 32'h140, 1, 0, 0, 32'h0);
        check_eq("tpnt_pc", pc_redirect, 32'h140);
        check_eq("tpnt_sel", {30'd0, next_pc_sel}, 32'd2);
        tick();
        idle(0);
        check_eq("tpnt_after_vld", {31'd0, redirect_valid}, 32'd0);
        tick();

        // Not-taken mispredicts, including the wrap at the top of memory.
        cyc(1, 0, 0, 5'b11000, 32'h200, 32'h999, 0, 1, 0, 32'h0);
        check_eq("ntpt_pc", pc_redirect, 32'h204);
        tick();
        cyc(1, 0, 0, 5'b11000, 32'hFFFF_FFFC, 32'h999, 0, 1, 0, 32'h0);
        check_eq("ntpt_wrap_pc", pc_redirect, 32'h0);
        tick();

        // Pending redirect with fetch stalled 3 cycles; a second event is masked.
        flushes = 0;
        cyc(1, 1, 0, 5'b11000, 32'h40, 32'h80, 1, 0, 0, 32'h0);
        flushes += int'(flush_D);
        tick();
        cyc(1, 1, 0, 5'b11000, 32'h44, 32'h500, 1, 0, 0, 32'h0);
        check_eq("pend_mask_pc", pc_redirect, 32'h80);
        flushes += int'(flush_D);
        tick();
        cyc(1, 1, 0, 5'b11000, 32'h44, 32'h500, 1, 0, 0, 32'h0);
        flushes += int'(flush_D);
        tick();
        cyc(1, 0, 0, 5'b11000, 32'h44, 32'h500, 1, 0, 0, 32'h0);
        check_eq("pend_release_pc", pc_redirect, 32'h80);
        flushes += int'(flush_D);
        tick();
        idle(0);
        flushes += int'(flush_D);
        check_eq("pend_flush_cycles", flushes, 32'd4);
        check_eq("pend_hold_pc", pc_redirect, 32'h80);
        tick();

        // Redirect beats the predictor.
        cyc(1, 0, 0, 5'b11000, 32'h400, 32'h0, 0, 1, 1, 32'h300);
        check_eq("prio_sel", {30'd0, next_pc_sel}, 32'd2);
        check_eq("prio_pc", pc_redirect, 32'h404);
        tick();
        idle(0);
        tick();

        // Event under stall is ignored until stall drops.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 1, 5'b11000, 32'h600, 32'h700, 1, 0, 0, 32'h0);
            check_eq("stall_no_redir", {31'd0, redirect_valid}, 32'd0);
            tick();
        end
        cyc(1, 0, 0, 5'b11000, 32'h600, 32'h700, 1, 0, 0, 32'h0);
        check_eq("stall_release_pc", pc_redirect, 32'h700);
        tick();

        // JALR redirect.
        cyc(1, 0, 0, 5'b11001, 32'h800, 32'h2468, 0, 0, 0, 32'h0);
        check_eq("jalr_pc", pc_redirect, 32'h2468);
        tick();

        // Counters: 5 branches, 2 mispredicted, from a fresh reset.
        cyc(0, 0, 0, 5'b00000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 5'b11000, 32'h1000 + 32'(i * 4), 32'h3000, (i == 1), (i == 3), 0, 32'h0);
            tick();
        end
        idle(0);
`ifdef BPU_PERF_EN
        check_eq("cnt_branch", branch_cnt, 32'd5);
        check_eq("cnt_mispred", mispred_cnt, 32'd2);
`else
        check_eq("cnt_branch_off", branch_cnt, 32'd0);
        check_eq("cnt_mispred_off", mispred_cnt, 32'd0);
`endif
        tick();

        // Reset asserted while PEND drops everything at once.
        cyc(1, 1, 0, 5'b11000, 32'h40, 32'h88, 1, 0, 0, 32'h0);
        tick();
        cyc(0, 1, 0, 5'b11000, 32'h40, 32'h88, 1, 0, 0, 32'h0);
        check_eq("rst_pend_vld", {31'd0, redirect_valid}, 32'd0);
        check_eq("rst_pend_cnt", branch_cnt, 32'd0);
        check_eq("rst_pend_pc", pc_redirect, TB_RESET_PC);
        tick();
        idle(0);
        check_eq("rst_pend_idle", {31'd0, redirect_valid}, 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    op = 5'b11000;
                2:       op = 5'b11001;
                default: op = 5'($urandom);
            endcase
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2), op,
                rpc, $urandom & 32'hFFFF_FFFE, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
